mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester and the load/store requester of the DLX datapath.
- Sequences each access through a fixed-latency memory.
- Performs big-endian byte-lane steering for stores and sign/zero extension for loads, driven by the decoded dataSize/memSign controls.
- Handles fetch flush on taken branch/jump and alignment faults.

Parameters:
- MEM_LAT, 2: memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.
- MAX_STREAK, 4: maximum number of consecutive data grants while if_req is pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; level; held with if_addr until if_ack or if_err.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle pulse; fetch complete, if_rdata valid.
- if_err  out  1  one-cycle pulse; misaligned fetch.
- if_rdata  out  32  fetched instruction word.
- flush  in  1  taken branch/jump; discards an outstanding or newly requested fetch.
- d_req  in  1  data request; level; held with all d_* fields until d_ack.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_size  in  2  00 = byte, 01 = half, 11 = word; 10 is treated as word.
- d_sign  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- d_ack  out  1  one-cycle pulse; data access complete.
- d_err  out  1  asserted together with d_ack when the data access is misaligned.
- d_rdata  out  32  extended load data; 0 for stores and errors.
- mem_en  out  1  one-cycle memory strobe.
- mem_wr  out  1  write qualifier; valid with mem_en.
- mem_addr  out  32  word address; bits 1:0 forced to 0.
- mem_be  out  4  byte enables; bit 3 = bits 31:24.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  valid in cycle T+MEM_LAT, where T is the mem_en cycle.
- grant_d  out  1  1 while the current transaction belongs to the data requester.

Behaviour:

Interface timing:
- One clock; reset is synchronous and active-high.
- All outputs are registered.

Reset:
- State = IDLE.
- All outputs = 0.
- Streak counter = 0; latency counter = 0.
- A reset asserted mid-transaction abandons the access. No ack or err is issued for it, and the requester re-presents it after reset.

States:
- IDLE: sample requests and select a winner.
  - Winner rule: if d_req=1, data wins, unless if_req=1 && flush=0 && streak==MAX_STREAK, in which case fetch wins.
  - If fetch is granted, streak is cleared.
  - If data is granted, streak is incremented, saturating at MAX_STREAK.
  - If if_req=1 && flush=1 and no data request is present, no grant is made and the state stays IDLE.
  - On a grant, latch address/size/sign/wr/wdata and check alignment:
    - fetch: if_addr[1:0] must be 00;
    - half: d_addr[0] must be 0;
    - word: d_addr[1:0] must be 00.
  - Aligned access: mem_en<=1 and go to WAIT with cnt<=MEM_LAT.
  - Misaligned access: no memory access; go to RESP with the error flag set.
- WAIT: mem_en is high only in the first WAIT cycle (T).
  - cnt decrements each cycle.
  - In cycle T+MEM_LAT (cnt==0), capture mem_rdata, then go to RESP.
- RESP: exactly one cycle of ack (plus err if flagged), then go to IDLE.
  - Requests are not sampled in RESP.
  - The requester may deassert its request or change its fields during RESP.

Latency and throughput:
- Request first seen in IDLE at cycle R gives mem_en at R+1 and ack at R+MEM_LAT+2.
- Throughput is one access per MEM_LAT+3 cycles.
- Misaligned access: err at R+2.

Flush:
- flush=1 in any cycle while a fetch is in WAIT or RESP sets a kill flag.
- With the kill flag set, the memory cycle still completes, but if_ack/if_err are suppressed in RESP.
- The kill flag is cleared on entry to IDLE.

Stores:
- mem_wr=1 together with mem_en.
- Byte: mem_wdata = the byte replicated to all 4 lanes; mem_be = 1000 >> addr[1:0].
- Half: mem_wdata = the halfword replicated to both halves; mem_be = 1100 when addr[1]=0, 0011 when addr[1]=1.
- Word: mem_be = 1111.
- d_rdata = 0 on a store.

Loads (big-endian):
- Byte lane = mem_rdata[31-8*addr[1:0] -: 8].
- Half lane = mem_rdata[31:16] when addr[1]=0, else mem_rdata[15:0].
- Extend to 32 bits per d_sign.
- Fetch always returns the full word with mem_be=1111.

Idle outputs:
- mem_* outputs other than mem_en hold their last values.
- grant_d is valid from WAIT through RESP and is 0 in IDLE.

Test Plan:
1. MEM_LAT=2: if_req=1, if_addr=0x100 at cycle 0, mem_rdata=0x20420005 at cycle 3 -> mem_en at cycle 1 with mem_addr=0x100 and mem_be=1111; if_ack=1 at cycle 4 with if_rdata=0x20420005.
2. Load byte, d_size=00, d_sign=1, d_addr=0x203, mem_rdata=0x112233F0 -> d_rdata=0xFFFFFFF0. Repeat with d_sign=0 -> 0x000000F0. Half load, addr=0x202, mem_rdata=0x1122_8001, d_sign=1 -> 0xFFFF8001.
3. Store half, d_addr=0x206, d_wdata=0x0000ABCD -> mem_wr=1, mem_be=0011, mem_wdata=0xABCDABCD; d_ack=1 with d_rdata=0.
4. d_req and if_req held high continuously, MAX_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F. if_ack never starves.
5. Fetch granted, flush=1 during WAIT -> mem_en still issued, no if_ack. The next if_req is granted normally after IDLE.
6. Word load at d_addr=0x201 -> no mem_en; d_ack=d_err=1 two cycles after request. Additionally, reset asserted in WAIT -> all outputs 0 next cycle and no ack ever issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - unified memory port arbiter for fetch and load/store requesters
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        flush,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        grant_d
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, streak;
  logic        is_d, is_wr, sgn, kill, err_f;
  logic [1:0]  lo, sz;
  logic        data_win, fetch_win, misal, kill_n;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, ld_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    data_win  = d_req && !(if_req && !flush && streak == 4'(MAX_STREAK));
    fetch_win = !data_win && if_req && !flush;
    misal     = |if_addr[1:0];
    if (data_win) begin
      case (d_size)
        2'b00:   misal = 1'b0;
        2'b01:   misal = d_addr[0];
        default: misal = |d_addr[1:0];
      endcase
    end
    kill_n = kill | (flush & ~is_d);
  end

  // Big-endian lane steering: byte 0 of the word lives in bits 31:24.
  always_comb begin
    be_n    = 4'hf;
    wdata_n = d_wdata;
    case (d_size)
      2'b00: begin
        be_n    = 4'b1000 >> d_addr[1:0];
        wdata_n = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = d_addr[1] ? 4'b0011 : 4'b1100;
        wdata_n = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = mem_rdata[7:0];
    case (lo)
      2'd0:    lane_b = mem_rdata[31:24];
      2'd1:    lane_b = mem_rdata[23:16];
      2'd2:    lane_b = mem_rdata[15:8];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h  = lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    ld_data = mem_rdata;
    case (sz)
      2'b00:   ld_data = sgn ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      2'b01:   ld_data = sgn ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (data_win || fetch_win) state_n = WAIT;
      WAIT:    if (cnt == 4'd0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; streak <= '0; is_d <= 1'b0; is_wr <= 1'b0; sgn <= 1'b0;
      kill <= 1'b0; err_f <= 1'b0; lo <= '0; sz <= '0;
      if_ack <= 1'b0; if_err <= 1'b0; if_rdata <= '0;
      d_ack <= 1'b0; d_err <= 1'b0; d_rdata <= '0;
      mem_en <= 1'b0; mem_wr <= 1'b0; mem_addr <= '0; mem_be <= '0; mem_wdata <= '0;
      grant_d <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (data_win || fetch_win) begin
            is_d    <= data_win;
            grant_d <= data_win;
            is_wr   <= data_win & d_wr;
            sgn     <= d_sign;
            lo      <= data_win ? d_addr[1:0] : if_addr[1:0];
            sz      <= data_win ? d_size : 2'b11;
            err_f   <= misal;
            if (fetch_win)                         streak <= '0;
            else if (streak != 4'(MAX_STREAK))     streak <= streak + 4'd1;
            // A misaligned access skips memory but still spends one WAIT cycle,
            // so its error response lands two cycles after the request.
            cnt <= misal ? 4'd0 : 4'(MEM_LAT);
            if (!misal) begin
              mem_en <= 1'b1;
              mem_wr <= data_win & d_wr;
              if (data_win) begin
                mem_addr  <= {d_addr[31:2], 2'b00};
                mem_be    <= be_n;
                mem_wdata <= wdata_n;
              end else begin
                mem_addr <= {if_addr[31:2], 2'b00};
                mem_be   <= 4'hf;
              end
            end
          end
        end
        WAIT: begin
          kill <= kill_n;
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else if (is_d) begin
            d_ack   <= 1'b1;
            d_err   <= err_f;
            d_rdata <= (err_f || is_wr) ? 32'h0 : ld_data;
          end else if (!kill_n) begin
            if_ack <= ~err_f;
            if_err <= err_f;
            if (!err_f) if_rdata <= mem_rdata;
          end
        end
        RESP: begin
          kill    <= 1'b0;
          grant_d <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, flush, d_req, d_wr, d_sign;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]  d_size;
  logic        if_ack, if_err, d_ack, d_err, mem_en, mem_wr, grant_d;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int passed = 0;
  int total  = 0;

  logic        en1, wr1, ack4, err4;
  logic [31:0] addr1, wd1, rd4;
  logic [3:0]  be1;

  wire [138:0] outs = {if_ack, if_err, if_rdata, d_ack, d_err, d_rdata, mem_en, mem_wr,
                       mem_addr, mem_be, mem_wdata, grant_d};

  mem_port_arbiter #(.MEM_LAT(2), .MAX_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .flush(flush),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_sign(d_sign), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; if_req = 1'b0; flush = 1'b0; d_req = 1'b0; d_wr = 1'b0; d_sign = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_size = 2'b11; mem_rdata = 32'hDEADBEEF;
    tick; tick;
    reset = 1'b0;
  endtask

  // Runs one aligned data access; request presented in cycle 0, ack expected in cycle 4.
  task automatic data_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic sign, input logic [31:0] rdata);
    d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata; d_size = size; d_sign = sign;
    mem_rdata = 32'hDEADBEEF;
    tick;
    en1 = mem_en; wr1 = mem_wr; addr1 = mem_addr; be1 = mem_be; wd1 = mem_wdata;
    tick; tick;
    mem_rdata = rdata;
    tick;
    ack4 = d_ack; err4 = d_err; rd4 = d_rdata;
    d_req = 1'b0; mem_rdata = 32'hDEADBEEF;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (outs !== 139'h0) $display("FAIL reset_outputs: got %h expected 0", outs); else passed++;
  endtask

  task automatic test_fetch;
    do_reset;
    if_req = 1'b1; if_addr = 32'h100;
    tick;
    total++; if (mem_en !== 1'b1) $display("FAIL fetch_mem_en: got %b expected 1", mem_en); else passed++;
    total++; if (mem_addr !== 32'h100) $display("FAIL fetch_mem_addr: got %h expected 00000100", mem_addr); else passed++;
    total++; if (mem_be !== 4'hf) $display("FAIL fetch_mem_be: got %b expected 1111", mem_be); else passed++;
    total++; if (grant_d !== 1'b0) $display("FAIL fetch_grant_d: got %b expected 0", grant_d); else passed++;
    tick;
    total++; if (mem_en !== 1'b0) $display("FAIL fetch_en_pulse: got %b expected 0", mem_en); else passed++;
    tick;
    mem_rdata = 32'h20420005;
    total++; if (if_ack !== 1'b0) $display("FAIL fetch_early_ack: got %b expected 0", if_ack); else passed++;
    tick;
    mem_rdata = 32'hDEADBEEF;
    total++; if (if_ack !== 1'b1) $display("FAIL fetch_ack: got %b expected 1", if_ack); else passed++;
    total++; if (if_rdata !== 32'h20420005) $display("FAIL fetch_rdata: got %h expected 20420005", if_rdata); else passed++;
    if_req = 1'b0;
    tick;
    total++; if (if_ack !== 1'b0) $display("FAIL fetch_ack_pulse: got %b expected 0", if_ack); else passed++;
  endtask

  task automatic test_load;
    do_reset;
    data_xfer(1'b0, 32'h203, 32'h0, 2'b00, 1'b1, 32'h112233F0);
    total++; if (addr1 !== 32'h200) $display("FAIL lb_addr: got %h expected 00000200", addr1); else passed++;
    total++; if (be1 !== 4'b0001) $display("FAIL lb_be: got %b expected 0001", be1); else passed++;
    total++; if (wr1 !== 1'b0) $display("FAIL lb_wr: got %b expected 0", wr1); else passed++;
    total++; if (ack4 !== 1'b1) $display("FAIL lb_ack: got %b expected 1", ack4); else passed++;
    total++; if (rd4 !== 32'hFFFFFFF0) $display("FAIL lb_sext: got %h expected fffffff0", rd4); else passed++;
    data_xfer(1'b0, 32'h203, 32'h0, 2'b00, 1'b0, 32'h112233F0);
    total++; if (rd4 !== 32'h000000F0) $display("FAIL lbu_zext: got %h expected 000000f0", rd4); else passed++;
    data_xfer(1'b0, 32'h202, 32'h0, 2'b01, 1'b1, 32'h11228001);
    total++; if (rd4 !== 32'hFFFF8001) $display("FAIL lh_sext: got %h expected ffff8001", rd4); else passed++;
    total++; if (be1 !== 4'b0011) $display("FAIL lh_be: got %b expected 0011", be1); else passed++;
    data_xfer(1'b0, 32'h200, 32'h0, 2'b01, 1'b0, 32'h80011122);
    total++; if (rd4 !== 32'h00008001) $display("FAIL lhu_upper: got %h expected 00008001", rd4); else passed++;
    data_xfer(1'b0, 32'h200, 32'h0, 2'b00, 1'b1, 32'h7F8899AA);
    total++; if (rd4 !== 32'h0000007F) $display("FAIL lb_lane0: got %h expected 0000007f", rd4); else passed++;
    data_xfer(1'b0, 32'h204, 32'h0, 2'b10, 1'b1, 32'hCAFEF00D);
    total++; if (rd4 !== 32'hCAFEF00D) $display("FAIL lw_size10: got %h expected cafef00d", rd4); else passed++;
  endtask

  task automatic test_store;
    do_reset;
    data_xfer(1'b1, 32'h206, 32'h0000ABCD, 2'b01, 1'b0, 32'h55555555);
    total++; if (en1 !== 1'b1 || wr1 !== 1'b1) $display("FAIL sh_en_wr: got %b%b expected 11", en1, wr1); else passed++;
    total++; if (addr1 !== 32'h204) $display("FAIL sh_addr: got %h expected 00000204", addr1); else passed++;
    total++; if (be1 !== 4'b0011) $display("FAIL sh_be: got %b expected 0011", be1); else passed++;
    total++; if (wd1 !== 32'hABCDABCD) $display("FAIL sh_wdata: got %h expected abcdabcd", wd1); else passed++;
    total++; if (ack4 !== 1'b1 || err4 !== 1'b0) $display("FAIL sh_ack: got %b%b expected 10", ack4, err4); else passed++;
    total++; if (rd4 !== 32'h0) $display("FAIL sh_rdata: got %h expected 00000000", rd4); else passed++;
    data_xfer(1'b1, 32'h201, 32'h1234565A, 2'b00, 1'b0, 32'h55555555);
    total++; if (be1 !== 4'b0100) $display("FAIL sb_be: got %b expected 0100", be1); else passed++;
    total++; if (wd1 !== 32'h5A5A5A5A) $display("FAIL sb_wdata: got %h expected 5a5a5a5a", wd1); else passed++;
    data_xfer(1'b1, 32'h208, 32'h89ABCDEF, 2'b11, 1'b0, 32'h55555555);
    total++; if (be1 !== 4'hf || wd1 !== 32'h89ABCDEF) $display("FAIL sw_be_wdata: got %b %h expected 1111 89abcdef", be1, wd1); else passed++;
  endtask

  task automatic test_streak;
    logic [9:0] order;
    int ng, nf;
    do_reset;
    order = '0; ng = 0; nf = 0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h300; d_size = 2'b11;
    if_req = 1'b1; if_addr = 32'h400;
    for (int c = 0; c < 120 && ng < 10; c++) begin
      tick;
      if (if_ack) nf++;
      if (mem_en) begin
        order[ng] = grant_d;
        ng++;
      end
    end
    total++; if (ng !== 10) $display("FAIL streak_grants: got %0d expected 10", ng); else passed++;
    total++; if (order !== 10'b0111101111) $display("FAIL streak_order: got %b expected 0111101111", order); else passed++;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (if_ack) nf++;
    end
    total++; if (nf !== 2) $display("FAIL streak_fetch_acks: got %0d expected 2", nf); else passed++;
    d_req = 1'b0; if_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_flush;
    int na, ne;
    logic got;
    do_reset;
    na = 0; ne = 0; got = 1'b0;
    if_req = 1'b1; if_addr = 32'h500; mem_rdata = 32'h12345678;
    tick;
    total++; if (mem_en !== 1'b1) $display("FAIL flush_mem_en: got %b expected 1", mem_en); else passed++;
    flush = 1'b1;
    tick;
    flush = 1'b0; if_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (if_ack || if_err) na++;
    end
    total++; if (na !== 0) $display("FAIL flush_suppressed: got %0d acks expected 0", na); else passed++;
    if_req = 1'b1; if_addr = 32'h600;
    for (int c = 0; c < 10 && !got; c++) begin
      tick;
      if (mem_en && mem_addr == 32'h600) ne++;
      if (if_ack) got = 1'b1;
    end
    total++; if (ne !== 1) $display("FAIL flush_refetch_en: got %0d expected 1", ne); else passed++;
    total++; if (got !== 1'b1) $display("FAIL flush_refetch_ack: got %b expected 1", got); else passed++;
    total++; if (if_rdata !== 32'h12345678) $display("FAIL flush_refetch_data: got %h expected 12345678", if_rdata); else passed++;
    if_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_misaligned;
    do_reset;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h201; d_size = 2'b11; d_sign = 1'b0;
    tick;
    total++; if (mem_en !== 1'b0 || d_ack !== 1'b0) $display("FAIL mis_c1: got en=%b ack=%b expected 0 0", mem_en, d_ack); else passed++;
    tick;
    total++; if (d_ack !== 1'b1 || d_err !== 1'b1) $display("FAIL mis_ack_err: got %b%b expected 11", d_ack, d_err); else passed++;
    total++; if (d_rdata !== 32'h0 || mem_en !== 1'b0) $display("FAIL mis_rdata_en: got %h %b expected 0 0", d_rdata, mem_en); else passed++;
    d_req = 1'b0;
    tick;
    total++; if (d_ack !== 1'b0) $display("FAIL mis_ack_pulse: got %b expected 0", d_ack); else passed++;
    tick;
    if_req = 1'b1; if_addr = 32'h102;
    tick;
    total++; if (mem_en !== 1'b0) $display("FAIL mis_fetch_en: got %b expected 0", mem_en); else passed++;
    tick;
    total++; if (if_err !== 1'b1 || if_ack !== 1'b0) $display("FAIL mis_fetch_err: got err=%b ack=%b expected 1 0", if_err, if_ack); else passed++;
    if_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_reset_mid;
    int na;
    do_reset;
    na = 0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h300; d_size = 2'b11;
    tick;
    tick;
    reset = 1'b1;
    tick;
    total++; if (outs !== 139'h0) $display("FAIL reset_mid_outputs: got %h expected 0", outs); else passed++;
    reset = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (d_ack || mem_en) na++;
    end
    total++; if (na !== 0) $display("FAIL reset_mid_no_ack: got %0d events expected 0", na); else passed++;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_load;
    test_store;
    test_streak;
    test_flush;
    test_misaligned;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
